// File: rtl/cheshire_reg_err_slv.sv
// Error slave for the register demux: terminates every access routed to its error port.
// Latency: response strobe RespLatency+1 cycles after the request is first seen.
// Backpressure: the master holds req_valid_i until rsp_ready_o; dropping it early aborts the access.
//
// Optional logging is enabled by defining CHESHIRE_REG_ERR_LOG_EN. Without it the err_* outputs
// and err_irq_o are tied low and err_clear_i is ignored; the response path is the same in both builds.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_write_i/req_addr_i incoming register request (held until rsp_ready_o)
//   rsp_ready_o/rsp_error_o/rsp_rdata_o one-cycle error response; error/rdata are zero otherwise
//   err_clear_i                        clears capture, count and irq
//   err_valid_o/err_addr_o/err_write_o first captured fault since the last clear
//   err_count_o                        saturating fault count
//   err_irq_o                          level interrupt, mirrors err_valid_o
module cheshire_reg_err_slv #(
  parameter int unsigned          AddrWidth   = 48,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          RespLatency = 2,
  parameter logic [DataWidth-1:0] ErrRdata    = DataWidth'(32'hBADCAB1E),
  parameter int unsigned          CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_ready_o,
  output logic                 rsp_error_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  input  logic                 err_clear_i,
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_write_o,
  output logic [CntWidth-1:0]  err_count_o,
  output logic                 err_irq_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [3:0] LatInit = 4'(RespLatency);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (LatInit == 4'd0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatInit;
          end
        end
      end
      StWait: begin
        // A master that withdraws its request mid-wait gets no response and leaves no log entry.
        if (!req_valid_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rsp_ready_o = (state_q == StResp);
  assign rsp_error_o = rsp_ready_o;
  assign rsp_rdata_o = rsp_ready_o ? ErrRdata : '0;

`ifdef CHESHIRE_REG_ERR_LOG_EN
  logic                 err_valid_q, err_valid_d;
  logic [AddrWidth-1:0] err_addr_q,  err_addr_d;
  logic                 err_write_q, err_write_d;
  logic [CntWidth-1:0]  err_count_q, err_count_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_count_q <= err_count_d;
    end
  end

  // Clear is applied first so that a fault logged in the same cycle survives it
  // and becomes the new first capture with a count of one.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_count_d = err_count_q;
    if (err_clear_i) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_write_d = 1'b0;
      err_count_d = '0;
    end
    // The fault is logged as the response goes out; the master still holds its request then.
    if (rsp_ready_o) begin
      if (!err_valid_d) begin
        err_valid_d = 1'b1;
        err_addr_d  = req_addr_i;
        err_write_d = req_write_i;
      end
      if (err_count_d != {CntWidth{1'b1}}) begin
        err_count_d = err_count_d + CntWidth'(1);
      end
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_write_o = err_write_q;
  assign err_count_o = err_count_q;
  assign err_irq_o   = err_valid_q;
`else
  // Request attributes and clear only feed the log, which is absent in this build.
  logic unused_log_inputs;
  assign unused_log_inputs = ^{err_clear_i, req_write_i, req_addr_i};

  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_write_o = 1'b0;
  assign err_count_o = '0;
  assign err_irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cheshire_reg_err_slv.sv
module tb_cheshire_reg_err_slv;

  localparam int unsigned AW  = 48;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam logic [DW-1:0] ERR_RDATA = 32'hBADCAB1E;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          err_clear = 1'b0;

  logic          rdy_a, err_a, ev_a, ew_a, irq_a;
  logic [DW-1:0] rdata_a;
  logic [AW-1:0] ea_a;
  logic [15:0]   cnt_a;
  logic          rdy_b, err_b, ev_b, ew_b, irq_b;
  logic [DW-1:0] rdata_b;
  logic [AW-1:0] ea_b;
  logic [3:0]    cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference log state: first fault since clear plus unbounded-then-clamped counts.
  bit            m_valid;
  logic [AW-1:0] m_addr;
  bit            m_write;
  int            m_cnt;
  int            m_cnt4;

  always #5 clk = ~clk;

  cheshire_reg_err_slv #(.AddrWidth(AW), .DataWidth(DW), .RespLatency(LAT),
                         .ErrRdata(ERR_RDATA), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .rsp_ready_o(rdy_a), .rsp_error_o(err_a), .rsp_rdata_o(rdata_a),
    .err_clear_i(err_clear), .err_valid_o(ev_a), .err_addr_o(ea_a), .err_write_o(ew_a),
    .err_count_o(cnt_a), .err_irq_o(irq_a));

  cheshire_reg_err_slv #(.AddrWidth(AW), .DataWidth(DW), .RespLatency(LAT),
                         .ErrRdata(ERR_RDATA), .CntWidth(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .rsp_ready_o(rdy_b), .rsp_error_o(err_b), .rsp_rdata_o(rdata_b),
    .err_clear_i(err_clear), .err_valid_o(ev_b), .err_addr_o(ea_b), .err_write_o(ew_b),
    .err_count_o(cnt_b), .err_irq_o(irq_b));

  task automatic model_clear();
    m_valid = 0; m_addr = '0; m_write = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_fault(input logic [AW-1:0] a, input logic w, input bit clr);
    if (clr) model_clear();
    if (!m_valid) begin
      m_valid = 1; m_addr = a; m_write = w;
    end
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt4 < 15) m_cnt4++;
  endtask

  task automatic model_expect(output logic [66:0] e16, output logic [54:0] e4);
`ifdef CHESHIRE_REG_ERR_LOG_EN
    e16 = {m_valid, m_addr, m_write, 16'(m_cnt), m_valid};
    e4  = {m_valid, m_addr, m_write, 4'(m_cnt4), m_valid};
`else
    e16 = '0;
    e4  = '0;
`endif
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[AW-1:0];
  endfunction

  // One request held until its response, optionally with a clear pulse in the response cycle.
  task automatic access(input logic [AW-1:0] addr, input logic wr, input bit clr_in_resp, input string name);
    bit            seen;
    int            lat;
    logic [DW:0]   rsp_a;
    logic [DW+1:0] rsp_b;
    logic [66:0]   e16;
    logic [54:0]   e4;
    seen = 0; lat = -1; rsp_a = '0; rsp_b = '0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rdy_a) begin
        seen = 1; lat = c;
        rsp_a = {err_a, rdata_a};
        rsp_b = {rdy_b, err_b, rdata_b};
        if (clr_in_resp) err_clear = 1'b1;
      end else begin
        n_cmp++;
        if ({err_a, rdata_a} !== '0) begin
          n_bad++;
          $display("FAIL %s idle_rsp: got err=%b rdata=%h, want 0/0", name, err_a, rdata_a);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; err_clear = 1'b0;
    n_cmp++;
    if (!seen || lat != LAT + 1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (seen=%0d), want %0d", name, lat, seen, LAT + 1);
    end
    if (seen) begin
      model_fault(addr, wr, clr_in_resp);
      n_cmp++;
      if (rsp_a !== {1'b1, ERR_RDATA}) begin
        n_bad++;
        $display("FAIL %s rsp: got %h, want %h", name, rsp_a, {1'b1, ERR_RDATA});
      end
      n_cmp++;
      if (rsp_b !== {2'b11, ERR_RDATA}) begin
        n_bad++;
        $display("FAIL %s rsp_sat: got %h, want %h", name, rsp_b, {2'b11, ERR_RDATA});
      end
    end
    model_expect(e16, e4);
    n_cmp++;
    if ({ev_a, ea_a, ew_a, cnt_a, irq_a} !== e16) begin
      n_bad++;
      $display("FAIL %s log: got %h, want %h", name, {ev_a, ea_a, ew_a, cnt_a, irq_a}, e16);
    end
    n_cmp++;
    if ({ev_b, ea_b, ew_b, cnt_b, irq_b} !== e4) begin
      n_bad++;
      $display("FAIL %s log_sat: got %h, want %h", name, {ev_b, ea_b, ew_b, cnt_b, irq_b}, e4);
    end
    @(negedge clk);
    n_cmp++;
    if ({rdy_a, rdy_b} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s single_pulse: got ready=%b%b, want 00", name, rdy_a, rdy_b);
    end
  endtask

  task automatic test_reset();
    logic [66:0] e16;
    logic [54:0] e4;
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rdy_a, err_a, rdata_a, ev_a, ea_a, ew_a, cnt_a, irq_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0", {rdy_a, err_a, rdata_a, ev_a, ea_a, ew_a, cnt_a, irq_a});
    end
    rst_n = 1'b1;
    @(negedge clk);
    model_expect(e16, e4);
    n_cmp++;
    if ({rdy_b, err_b, rdata_b, ev_b, ea_b, ew_b, cnt_b, irq_b} !== {34'b0, e4}) begin
      n_bad++;
      $display("FAIL reset_sat: got %h, want 0", {rdy_b, err_b, rdata_b, ev_b, ea_b, ew_b, cnt_b, irq_b});
    end
  endtask

  task automatic test_clear();
    logic [66:0] e16;
    logic [54:0] e4;
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    model_clear();
    model_expect(e16, e4);
    n_cmp++;
    if ({ev_a, ea_a, ew_a, cnt_a, irq_a} !== e16) begin
      n_bad++;
      $display("FAIL clear: got %h, want %h", {ev_a, ea_a, ew_a, cnt_a, irq_a}, e16);
    end
  endtask

  task automatic test_first_capture();
    access(48'h0000_0300_9000, 1'b0, 0, "read_9000");
    test_clear();
    access(48'h0000_0300_A000, 1'b1, 0, "write_A000");
    access(48'h0000_0300_B000, 1'b0, 0, "read_B000");
  endtask

  task automatic test_clear_in_resp();
    access(48'h0000_0300_C000, 1'b0, 1, "clr_resp_C000");
  endtask

  // Valid held high across responses: each response is followed by one IDLE cycle in which
  // the next request is accepted, then RespLatency+1 cycles to its response.
  task automatic test_back_to_back();
    int          pulses[17];
    int          got;
    int          cyc;
    logic [66:0] e16;
    logic [54:0] e4;
    test_clear();
    got = 0; cyc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = rand_addr(); req_write = 1'($urandom);
    while (got < 17 && cyc < 17 * (LAT + 2) + 20) begin
      @(negedge clk); cyc++;
      if (rdy_a) begin
        pulses[got] = cyc;
        model_fault(req_addr, req_write, 0);
        got++;
        @(posedge clk); #1;
        if (got == 17) req_valid = 1'b0;
        else begin
          req_addr = rand_addr(); req_write = 1'($urandom);
        end
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (got != 17) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d responses, want 17", got);
    end
    for (int i = 1; i < got; i++) begin
      n_cmp++;
      if (pulses[i] - pulses[i-1] != LAT + 2) begin
        n_bad++;
        $display("FAIL b2b_spacing[%0d]: got %0d, want %0d", i, pulses[i] - pulses[i-1], LAT + 2);
      end
    end
    model_expect(e16, e4);
    n_cmp++;
    if ({ev_a, ea_a, ew_a, cnt_a, irq_a} !== e16) begin
      n_bad++;
      $display("FAIL b2b_log: got %h, want %h", {ev_a, ea_a, ew_a, cnt_a, irq_a}, e16);
    end
    n_cmp++;
    if ({ev_b, ea_b, ew_b, cnt_b, irq_b} !== e4) begin
      n_bad++;
      $display("FAIL b2b_saturate: got %h, want %h", {ev_b, ea_b, ew_b, cnt_b, irq_b}, e4);
    end
  endtask

  task automatic test_abort();
    logic [66:0] e16;
    logic [54:0] e4;
    bit          pulse;
    // Request withdrawn while waiting.
    pulse = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 48'h0000_0300_D000; req_write = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (rdy_a || rdy_b) pulse = 1;
    end
    model_expect(e16, e4);
    n_cmp++;
    if ({pulse, ev_a, ea_a, ew_a, cnt_a, irq_a} !== {1'b0, e16}) begin
      n_bad++;
      $display("FAIL abort_drop: got pulse=%b log=%h, want 0/%h", pulse, {ev_a, ea_a, ew_a, cnt_a, irq_a}, e16);
    end
    // Reset while waiting.
    pulse = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 48'h0000_0300_E000; req_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0;
    model_clear();
    repeat (2) begin
      @(negedge clk);
      if (rdy_a || rdy_b) pulse = 1;
    end
    rst_n = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (rdy_a || rdy_b) pulse = 1;
    end
    n_cmp++;
    if ({pulse, ev_a, ea_a, ew_a, cnt_a, irq_a} !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: got pulse=%b log=%h, want 0/0", pulse, {ev_a, ea_a, ew_a, cnt_a, irq_a});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) test_clear();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      access(rand_addr(), 1'($urandom), ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_first_capture();
    test_clear_in_resp();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
